uart_tx_framer: RTL and testbench



---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Frame handshake between a byte source (master) and uart_tx_framer (slave).
interface uart_tx_if #(
    parameter int unsigned MAX_DATA_WIDTH = 8
);
    logic                      txValid;
    logic                      txReady;
    logic [MAX_DATA_WIDTH-1:0] txData;

    modport master (output txValid, output txData, input txReady);
    modport slave  (input txValid, input txData, output txReady);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 5..8 data bits LSB first, optional parity, 1..2 stop bits.
// Error injection (parity/framing/break) is compiled in by UART_TX_ERROR_INJECTION_EN.
module uart_tx_framer #(
    parameter int unsigned MAX_DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_if.slave             txIf,
    input  logic [3:0]           cfgDataWidth,
    input  logic                 cfgParityEnable,
    input  logic                 cfgParityType,
    input  logic [1:0]           cfgStopBits,
    input  logic [4:0]           cfgOverSampling,
    input  logic [DIV_WIDTH-1:0] cfgBaudDivisor,
    input  logic                 injParityError,
    input  logic                 injFramingError,
    input  logic                 injBreak,
    output logic                 tx,
    output logic                 busy,
    output logic                 frameDone
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OS_W  = 5;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [2:0]                state, stateNext;
    logic [DIV_WIDTH-1:0]      tickCnt, tickNext;
    logic [OS_W-1:0]           sampleCnt, sampleNext;
    logic [CNT_W-1:0]          bitCnt, bitNext;
    logic [MAX_DATA_WIDTH-1:0] dataQ, dataNext;
    logic                      txNext, frameDoneNext, txReadyQ, accept, bitEnd;

    logic [CNT_W-1:0]          widthQ;
    logic                      parEnQ, parBitQ, injFrameQ;
    logic [1:0]                stopsQ;
    logic [OS_W-1:0]           osQ;
    logic [DIV_WIDTH-1:0]      divQ;

    logic [CNT_W-1:0]          widthIn;
    logic [1:0]                stopsIn;
    logic [OS_W-1:0]           osIn;
    logic [DIV_WIDTH-1:0]      divIn;
    logic                      parityIn;
    logic                      injParIn, injFrameIn, injBreakIn;

`ifdef UART_TX_ERROR_INJECTION_EN
    assign injParIn   = injParityError;
    assign injFrameIn = injFramingError;
    assign injBreakIn = injBreak;
`else
    logic unusedInj;
    assign unusedInj  = injParityError ^ injFramingError ^ injBreak;
    assign injParIn   = 1'b0;
    assign injFrameIn = 1'b0;
    assign injBreakIn = 1'b0;
`endif

    assign txIf.txReady = txReadyQ;

    // Coerce configuration into its legal range and precompute the parity bit at accept
    always_comb begin
        widthIn = cfgDataWidth;
        if (cfgDataWidth < 4'd5)
            widthIn = 4'd5;
        else if (cfgDataWidth > CNT_W'(MAX_DATA_WIDTH))
            widthIn = CNT_W'(MAX_DATA_WIDTH);
        stopsIn  = cfgStopBits[1] ? 2'd2 : 2'd1;
        osIn     = (cfgOverSampling == 5'd13) ? 5'd13 : 5'd16;
        divIn    = (cfgBaudDivisor == '0) ? DIV_WIDTH'(1) : cfgBaudDivisor;
        parityIn = cfgParityType ^ injParIn;
        for (int i = 0; i < int'(MAX_DATA_WIDTH); i++) begin
            if (i < int'(widthIn))
                parityIn = parityIn ^ txIf.txData[i];
        end
    end

    // Next-state, bit timing and serial output
    always_comb begin
        stateNext  = state;
        txNext     = tx;
        bitNext    = bitCnt;
        dataNext   = dataQ;
        tickNext   = tickCnt;
        sampleNext = sampleCnt;
        accept     = txIf.txValid && txReadyQ;
        bitEnd     = (state != IDLE) && (tickCnt == divQ - DIV_WIDTH'(1))
                     && (sampleCnt == osQ - OS_W'(1));

        if (state != IDLE) begin
            if (tickCnt == divQ - DIV_WIDTH'(1)) begin
                tickNext   = '0;
                sampleNext = (sampleCnt == osQ - OS_W'(1)) ? '0 : sampleCnt + OS_W'(1);
            end else begin
                tickNext = tickCnt + DIV_WIDTH'(1);
            end
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = injBreakIn ? BREAK : START;
                    txNext    = 1'b0;
                    bitNext   = '0;
                    dataNext  = txIf.txData;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                    txNext    = dataQ[0];
                    dataNext  = dataQ >> 1;
                    bitNext   = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitCnt == widthQ - CNT_W'(1)) begin
                        if (parEnQ) begin
                            stateNext = PARITY;
                            txNext    = parBitQ;
                        end else begin
                            stateNext = STOP;
                            txNext    = ~injFrameQ;
                            bitNext   = CNT_W'(stopsQ) - CNT_W'(1);
                        end
                    end else begin
                        txNext   = dataQ[0];
                        dataNext = dataQ >> 1;
                        bitNext  = bitCnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    stateNext = STOP;
                    txNext    = ~injFrameQ;
                    bitNext   = CNT_W'(stopsQ) - CNT_W'(1);
                end
            end
            STOP: begin
                // bitCnt counts the stop bits still to send after this one
                if (bitEnd) begin
                    txNext = 1'b1;
                    if (bitCnt == '0)
                        stateNext = IDLE;
                    else
                        bitNext = bitCnt - CNT_W'(1);
                end
            end
            BREAK: begin
                // Low for start+data+parity+stop periods, then a single high stop period
                if (bitEnd) begin
                    if (bitCnt == widthQ + CNT_W'(parEnQ) + CNT_W'(stopsQ)) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                        bitNext   = '0;
                    end else begin
                        bitNext = bitCnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase

        frameDoneNext = (state == STOP) && (bitCnt == '0)
                        && (tickNext == divQ - DIV_WIDTH'(1))
                        && (sampleNext == osQ - OS_W'(1));
    end

    // State, counters, registered outputs and per-frame configuration latches
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            txReadyQ  <= 1'b0;
            tickCnt   <= '0;
            sampleCnt <= '0;
            bitCnt    <= '0;
            dataQ     <= '0;
            widthQ    <= '0;
            parEnQ    <= 1'b0;
            parBitQ   <= 1'b0;
            injFrameQ <= 1'b0;
            stopsQ    <= '0;
            osQ       <= '0;
            divQ      <= '0;
        end else begin
            state     <= stateNext;
            tx        <= txNext;
            busy      <= (stateNext != IDLE);
            frameDone <= frameDoneNext;
            txReadyQ  <= (stateNext == IDLE);
            tickCnt   <= tickNext;
            sampleCnt <= sampleNext;
            bitCnt    <= bitNext;
            dataQ     <= dataNext;
            if (accept) begin
                widthQ    <= widthIn;
                parEnQ    <= cfgParityEnable;
                parBitQ   <= parityIn;
                injFrameQ <= injFrameIn;
                stopsQ    <= stopsIn;
                osQ       <= osIn;
                divQ      <= divIn;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized bench for uart_tx_framer against a bit-list reference model of the frame.
module tb_uart_tx_framer;
    localparam int unsigned MAX_DATA_WIDTH = 8;
    localparam int unsigned DIV_WIDTH      = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           cfgDataWidth;
    logic                 cfgParityEnable, cfgParityType;
    logic [1:0]           cfgStopBits;
    logic [4:0]           cfgOverSampling;
    logic [DIV_WIDTH-1:0] cfgBaudDivisor;
    logic                 injParityError, injFramingError, injBreak;
    logic                 tx, busy, frameDone;

    int errCount   = 0;
    int checkCount = 0;
    int expBits[$];
    int expPeriod;
    int lastDoneAt;
    logic [31:0] lastSeq;

    uart_tx_if #(.MAX_DATA_WIDTH(MAX_DATA_WIDTH)) txIf ();

    uart_tx_framer #(.MAX_DATA_WIDTH(MAX_DATA_WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk(clk), .reset(reset), .txIf(txIf),
        .cfgDataWidth(cfgDataWidth), .cfgParityEnable(cfgParityEnable),
        .cfgParityType(cfgParityType), .cfgStopBits(cfgStopBits),
        .cfgOverSampling(cfgOverSampling), .cfgBaudDivisor(cfgBaudDivisor),
        .injParityError(injParityError), .injFramingError(injFramingError),
        .injBreak(injBreak), .tx(tx), .busy(busy), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference frame: list of line levels, one entry per bit period
    function automatic void buildFrame(input int d, w, pe, pt, sb, os, dv, ip, ifr, ib);
        int ew, es, eo, ed, par, b;
        bit injOn;
`ifdef UART_TX_ERROR_INJECTION_EN
        injOn = 1'b1;
`else
        injOn = 1'b0;
`endif
        ew = (w < 5) ? 5 : (w > int'(MAX_DATA_WIDTH)) ? int'(MAX_DATA_WIDTH) : w;
        es = (sb == 0) ? 1 : (sb == 3) ? 2 : sb;
        eo = (os == 13) ? 13 : 16;
        ed = (dv == 0) ? 1 : dv;
        expPeriod = ed * eo;
        expBits.delete();
        if (injOn && ib != 0) begin
            for (int i = 0; i < 1 + ew + pe + es; i++) expBits.push_back(0);
            expBits.push_back(1);
        end else begin
            par = 0;
            expBits.push_back(0);
            for (int i = 0; i < ew; i++) begin
                b = (d >> i) & 1;
                par ^= b;
                expBits.push_back(b);
            end
            if (pe != 0) expBits.push_back(par ^ pt ^ ((injOn && ip != 0) ? 1 : 0));
            for (int i = 0; i < es; i++)
                expBits.push_back((i == 0 && injOn && ifr != 0) ? 0 : 1);
        end
    endfunction

    task automatic scramble();
        txIf.txData     = 8'($urandom);
        cfgDataWidth    = 4'($urandom);
        cfgParityEnable = 1'($urandom);
        cfgParityType   = 1'($urandom);
        cfgStopBits     = 2'($urandom);
        cfgOverSampling = 5'($urandom);
        cfgBaudDivisor  = DIV_WIDTH'($urandom_range(0, 5));
        injParityError  = 1'($urandom);
        injFramingError = 1'($urandom);
        injBreak        = 1'($urandom);
    endtask

    task automatic startFrame(input int d, w, pe, pt, sb, os, dv, ip, ifr, ib, input bit keep);
        int waitCnt = 0;
        @(negedge clk);
        while (txIf.txReady !== 1'b1 && waitCnt < 5000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (txIf.txReady !== 1'b1) begin
            checkVal("readyTimeout", 32'd0, 32'd1);
            return;
        end
        txIf.txValid    = 1'b1;
        txIf.txData     = 8'(d);
        cfgDataWidth    = 4'(w);
        cfgParityEnable = 1'(pe);
        cfgParityType   = 1'(pt);
        cfgStopBits     = 2'(sb);
        cfgOverSampling = 5'(os);
        cfgBaudDivisor  = DIV_WIDTH'(dv);
        injParityError  = 1'(ip);
        injFramingError = 1'(ifr);
        injBreak        = 1'(ib);
        buildFrame(d, w, pe, pt, sb, os, dv, ip, ifr, ib);
        @(posedge clk);
        #1;
        if (!keep) begin
            txIf.txValid = 1'b0;
            scramble();
        end
    endtask

    // Walks one frame cycle by cycle from the first start-bit cycle
    task automatic checkFrame();
        int cyc = 0, dones = 0, busyLow = 0, hits;
        lastDoneAt = -1;
        lastSeq    = '0;
        for (int k = 0; k < expBits.size(); k++) begin
            hits = 0;
            for (int c = 0; c < expPeriod; c++) begin
                @(negedge clk);
                if (tx === 1'(expBits[k])) hits++;
                if (c == expPeriod / 2) lastSeq[k] = tx;
                if (frameDone === 1'b1) begin dones++; lastDoneAt = cyc; end
                if (busy !== 1'b1) busyLow++;
                cyc++;
            end
            checkVal($sformatf("bit%0d", k), hits, expPeriod);
        end
        checkVal("doneCount", dones, 1);
        checkVal("doneLast", lastDoneAt, cyc - 1);
        checkVal("busyLow", busyLow, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d, w, pe, pt, sb, os, dv, lowCnt, doneCnt;
        reset = 1'b1;
        txIf.txValid = 1'b0;
        txIf.txData = '0;
        cfgDataWidth = 4'd8; cfgParityEnable = 1'b0; cfgParityType = 1'b0;
        cfgStopBits = 2'd1; cfgOverSampling = 5'd16; cfgBaudDivisor = DIV_WIDTH'(1);
        injParityError = 1'b0; injFramingError = 1'b0; injBreak = 1'b0;

        repeat (3) @(negedge clk);
        checkVal("rstTx", tx, 1);
        checkVal("rstBusy", busy, 0);
        checkVal("rstDone", frameDone, 0);
        checkVal("rstReady", txIf.txReady, 0);
        reset = 1'b0;
        @(negedge clk);
        checkVal("relReady", txIf.txReady, 1);
        checkVal("relTx", tx, 1);

        // 8E1, 0xA5, divisor 1, oversampling 16
        startFrame(8'hA5, 8, 1, 0, 1, 16, 1, 0, 0, 0, 1'b0);
        checkFrame();
        checkVal("seqA5", lastSeq, 32'h54A);
        checkVal("lenA5", lastDoneAt + 1, 176);

        // 5O2, 0x1F
        startFrame(8'h1F, 5, 1, 1, 2, 16, 1, 0, 0, 0, 1'b0);
        checkFrame();
        checkVal("seq1F", lastSeq, 32'd446);

        // divisor 4, oversampling 13, config scrambled mid-frame
        startFrame(8'h3C, 8, 0, 0, 1, 13, 4, 0, 0, 0, 1'b0);
        checkFrame();
        checkVal("len52", lastDoneAt + 1, 520);

        // Back-to-back frames with txValid held high
        startFrame(8'h96, 7, 1, 0, 1, 16, 1, 0, 0, 0, 1'b1);
        checkFrame();
        @(negedge clk);
        checkVal("gapTx", tx, 1);
        checkVal("gapReady", txIf.txReady, 1);
        @(posedge clk);
        #1;
        txIf.txValid = 1'b0;
        scramble();
        checkFrame();

        // Reset in DATA aborts the frame
        startFrame(8'h00, 8, 0, 0, 1, 16, 1, 0, 0, 0, 1'b0);
        repeat (37) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkVal("abortTx", tx, 1);
        checkVal("abortBusy", busy, 0);
        checkVal("abortReady", txIf.txReady, 0);
        checkVal("abortDone", frameDone, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkVal("abortRelReady", txIf.txReady, 1);
        lowCnt = 0; doneCnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lowCnt++;
            if (frameDone === 1'b1) doneCnt++;
        end
        checkVal("abortQuietTx", lowCnt, 0);
        checkVal("abortNoDone", doneCnt, 0);

        // Error injection requests (ignored when the feature is compiled out)
        startFrame(8'h5A, 8, 0, 0, 1, 16, 1, 0, 1, 0, 1'b0);
        checkFrame();
        startFrame(8'h0F, 8, 0, 0, 1, 16, 1, 0, 0, 1, 1'b0);
        checkFrame();
`ifdef UART_TX_ERROR_INJECTION_EN
        checkVal("breakSeq", lastSeq, 32'd1024);
        checkVal("breakLen", lastDoneAt + 1, 176);
`else
        checkVal("noBreakLen", lastDoneAt + 1, 160);
`endif
        startFrame(8'h33, 6, 1, 1, 1, 16, 2, 1, 0, 0, 1'b0);
        checkFrame();

        // Randomized frames, including out-of-range configuration
        for (int n = 0; n < 12; n++) begin
            d  = int'($urandom_range(0, 255));
            w  = int'($urandom_range(0, 15));
            pe = int'($urandom_range(0, 1));
            pt = int'($urandom_range(0, 1));
            sb = int'($urandom_range(0, 3));
            os = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                             : (($urandom_range(0, 1) == 1) ? 13 : 16);
            dv = int'($urandom_range(0, 3));
            startFrame(d, w, pe, pt, sb, os, dv, int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 1 : 0, 1'b0);
            checkFrame();
            @(negedge clk);
            checkVal("idleTx", tx, 1);
            checkVal("idleBusy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
